na_job_sequencer: RTL and testbench
===================================

// Module: na_job_sequencer
// PURPOSE
//  Sequences the shared number analyzer (even / fibonacci / palindrome FSMs) over a stream of numbers.
//  Buffers incoming numbers and drives the analyzer's number and go_i for one job at a time.
//  Decodes each FSM's terminal states, latches the three verdicts and returns one result per job
//  over a valid/ready handshake. Sits between the number producers and the numberAnalyzer instance.
// PARAMETERS
//  FIFO_DEPTH      4     input job buffer entries (power of 2, >=2)
//  TIMEOUT_CYCLES  1024  RUN-state watchdog limit (used only with NA_SEQ_TIMEOUT_EN)
// PORTS
//  clk           in   1   clock, all logic on posedge
//  reset         in   1   synchronous, active-high
//  in_valid      in   1   producer offers in_number
//  in_ready      out  1   buffer not full; transfer when in_valid & in_ready
//  in_number     in   32  number to analyze
//  na_number     out  32  number driven to analyzer, held stable for whole job
//  na_go         out  1   analyzer go_i
//  na_reset      out  1   analyzer reset
//  na_st_even    in   2   even FSM state
//  na_st_fib     in   4   fibonacci FSM state
//  na_st_pal     in   4   palindrome FSM state
//  na_is_even / na_is_fib / na_is_pal  in  1 each  analyzer verdicts
//  res_valid     out  1   result available
//  res_ready     in   1   consumer accepts; transfer when res_valid & res_ready
//  res_number    out  32  number the result belongs to
//  res_flags     out  3   {pal, fib, even}
//  res_timeout   out  1   job aborted by watchdog
// BEHAVIOUR
//  Reset: FIFO empty, FSM=IDLE, na_go=0, na_reset=1, res_valid=0, res_* =0, na_number=0, in_ready=0.
//  Done decode: even done = st 2|3; fib done = st 7|8; pal done = st 6|9.
//  FSM:
//   IDLE: na_reset=0. If FIFO non-empty: pop into na_number -> START.
//   START (1 cycle): na_go=0, clear sticky done/flag regs -> RUN.
//   RUN: na_go=1. Each cycle a unit's done decode is high and its sticky bit clear: set sticky, latch verdict.
//        When all three sticky (incl. same cycle as last latch) -> RELEASE.
//   RELEASE: na_go=0; stay until no done decode is active (min 1 cycle) -> REPORT.
//   REPORT: res_valid=1, outputs stable until res_ready; on transfer -> IDLE.
//  Latency: empty system, no backpressure: res_valid >= 4 cycles after in_valid transfer + analyzer time.
//  FIFO: push and pop same cycle when full is allowed only if pop occurs (in_ready = !full, no bypass).
//   Pointers wrap modulo FIFO_DEPTH; order preserved strictly.
//  Verdicts latched at first done observation; later toggling of na_is_* in the job is ignored.
//  Reset mid-job: job and all buffered numbers discarded; no result emitted.
// CONFIGURATION
//  NA_SEQ_TIMEOUT_EN defined: 16-bit counter cleared in START, increments in RUN; at TIMEOUT_CYCLES
//   -> na_reset=1 for exactly 1 cycle, unlatched flags forced 0, res_timeout=1, then REPORT.
//  Undefined: no counter; RUN waits indefinitely; res_timeout tied 0; na_reset only follows reset.
// STRUCTURE
//  Package na_seq_pkg: state enum (IDLE,START,RUN,RELEASE,REPORT), done-state constants
//   EVEN_DONE_A/B=2/3, FIB_DONE_A/B=7/8, PAL_DONE_A/B=6/9, flag bit indices.
//  Sub-module na_seq_fifo (FIFO_DEPTH x 32 sync FIFO, push/pop/full/empty); FSM in top.
// TESTING (bench uses stub analyzer with programmable latency per unit)
//  Push 55, stubs done after 3/7/5 cycles, verdicts 0/1/1 -> one result: number=55, flags=3'b110, timeout=0.
//  Push 4 numbers back-to-back, res_ready low 10 cycles -> in_ready drops after 4th, results in order.
//  Units finish same cycle -> RUN->RELEASE next cycle; flags correct; na_go low in RELEASE.
//  Verdict toggles after done state -> res_flags reflect value at first done cycle.
//  Assert reset during RUN with 2 queued -> outputs to reset values, no result ever emitted for them.
//  NA_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=16, fib stub never done -> na_reset 1-cycle pulse, res_timeout=1, fib flag 0.

Source files
------------

// File: rtl/na_seq_pkg.sv
// Shared types and constants for the number-analyzer job sequencer.
// Holds the FSM state enum, the analyzer terminal-state encodings, the verdict
// bit positions and a helper that decodes the three units' done states.
package na_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        RUN,
        RELEASE,
        REPORT
    } seq_state_t;

    // Terminal states of each analyzer unit (either value means finished)
    localparam logic [1:0] EVEN_DONE_A = 2'd2;
    localparam logic [1:0] EVEN_DONE_B = 2'd3;
    localparam logic [3:0] FIB_DONE_A  = 4'd7;
    localparam logic [3:0] FIB_DONE_B  = 4'd8;
    localparam logic [3:0] PAL_DONE_A  = 4'd6;
    localparam logic [3:0] PAL_DONE_B  = 4'd9;

    // Bit positions in res_flags / internal sticky vectors: {pal, fib, even}
    localparam int FLAG_EVEN = 0;
    localparam int FLAG_FIB  = 1;
    localparam int FLAG_PAL  = 2;

    function automatic logic [2:0] decode_done(input logic [1:0] st_even,
                                               input logic [3:0] st_fib,
                                               input logic [3:0] st_pal);
        logic [2:0] d;
        d            = '0;
        d[FLAG_EVEN] = (st_even == EVEN_DONE_A) || (st_even == EVEN_DONE_B);
        d[FLAG_FIB]  = (st_fib  == FIB_DONE_A)  || (st_fib  == FIB_DONE_B);
        d[FLAG_PAL]  = (st_pal  == PAL_DONE_A)  || (st_pal  == PAL_DONE_B);
        return d;
    endfunction

endpackage

// File: rtl/na_seq_fifo.sv
// Synchronous FIFO buffering numbers waiting for the analyzer.
// DEPTH must be a power of two so the pointers wrap naturally. No bypass:
// a pushed word becomes visible on pop_data the cycle after the push.
module na_seq_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int            AW        = $clog2(DEPTH);
    localparam logic [AW:0]   DEPTH_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    // Ignore requests that would overflow or underflow
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign full     = (count == DEPTH_CNT);
    assign empty    = (count == '0);
    assign pop_data = mem[rd_ptr];

    // Storage array; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    // Pointer and occupancy tracking
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/na_job_sequencer.sv
// Job sequencer for the shared number analyzer (even / fibonacci / palindrome).
// Buffers incoming numbers, runs one analyzer job at a time, latches each unit's
// verdict at the first cycle its done state is seen, and returns one result per
// job over a valid/ready handshake.
// Optional watchdog: define NA_SEQ_TIMEOUT_EN to abort a job that stays in RUN
// for TIMEOUT_CYCLES cycles (analyzer reset pulse, res_timeout=1).
module na_job_sequencer
    import na_seq_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_number,
    output logic [31:0] na_number,
    output logic        na_go,
    output logic        na_reset,
    input  logic [1:0]  na_st_even,
    input  logic [3:0]  na_st_fib,
    input  logic [3:0]  na_st_pal,
    input  logic        na_is_even,
    input  logic        na_is_fib,
    input  logic        na_is_pal,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_number,
    output logic [2:0]  res_flags,
    output logic        res_timeout
);
    seq_state_t  state;
    logic        fifo_full;
    logic        fifo_empty;
    logic        fifo_push;
    logic        fifo_pop;
    logic [31:0] fifo_data;
    logic [2:0]  done_now;
    logic [2:0]  verdict;
    logic [2:0]  sticky;
    logic [2:0]  flags;
    logic [2:0]  latch_now;
    logic [2:0]  sticky_nxt;
    logic [2:0]  flags_nxt;

`ifdef NA_SEQ_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] tmo_cnt;
`else
    assign res_timeout = 1'b0;
`endif

    // Producers are held off while full and throughout reset
    assign in_ready  = !fifo_full && !reset;
    assign fifo_push = in_valid && in_ready;
    assign fifo_pop  = (state == IDLE) && !fifo_empty;

    na_seq_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (in_number),
        .pop       (fifo_pop),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Gather verdicts into flag order and work out which units latch this cycle
    always_comb begin
        verdict            = '0;
        verdict[FLAG_EVEN] = na_is_even;
        verdict[FLAG_FIB]  = na_is_fib;
        verdict[FLAG_PAL]  = na_is_pal;
    end

    assign done_now   = decode_done(na_st_even, na_st_fib, na_st_pal);
    assign latch_now  = done_now & ~sticky;
    assign sticky_nxt = sticky | done_now;
    assign flags_nxt  = (flags & ~latch_now) | (verdict & latch_now);

    // Job FSM with registered analyzer controls and result outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            na_go      <= 1'b0;
            na_reset   <= 1'b1;
            na_number  <= '0;
            sticky     <= '0;
            flags      <= '0;
            res_valid  <= 1'b0;
            res_number <= '0;
            res_flags  <= '0;
`ifdef NA_SEQ_TIMEOUT_EN
            res_timeout <= 1'b0;
            tmo_cnt     <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    na_reset <= 1'b0;
                    if (!fifo_empty) begin
                        na_number <= fifo_data;
                        state     <= START;
                    end
                end
                START: begin
                    sticky <= '0;
                    flags  <= '0;
                    na_go  <= 1'b1;
                    state  <= RUN;
`ifdef NA_SEQ_TIMEOUT_EN
                    tmo_cnt <= '0;
`endif
                end
                RUN: begin
                    sticky <= sticky_nxt;
                    flags  <= flags_nxt;
                    if (&sticky_nxt) begin
                        na_go <= 1'b0;
                        state <= RELEASE;
                    end
`ifdef NA_SEQ_TIMEOUT_EN
                    else if (tmo_cnt == TMO_LAST) begin
                        // Abort: kick the analyzer and report what was latched so far
                        na_go       <= 1'b0;
                        na_reset    <= 1'b1;
                        res_valid   <= 1'b1;
                        res_number  <= na_number;
                        res_flags   <= flags_nxt & sticky_nxt;
                        res_timeout <= 1'b1;
                        state       <= REPORT;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
`endif
                end
                RELEASE: begin
                    // Wait for every unit to leave its done state before reporting
                    if (done_now == '0) begin
                        res_valid  <= 1'b1;
                        res_number <= na_number;
                        res_flags  <= flags;
                        state      <= REPORT;
                    end
                end
                REPORT: begin
                    na_reset <= 1'b0;
                    if (res_ready) begin
                        res_valid  <= 1'b0;
                        res_number <= '0;
                        res_flags  <= '0;
                        state      <= IDLE;
`ifdef NA_SEQ_TIMEOUT_EN
                        res_timeout <= 1'b0;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_na_job_sequencer.sv
// Bench for na_job_sequencer with a stub analyzer whose per-unit latency is
// programmable. Stub verdicts are wrong until the unit reaches its done state,
// and can optionally flip after the first done cycle.
module tb_na_job_sequencer;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_number;
    logic [31:0] na_number;
    logic        na_go;
    logic        na_reset;
    logic [1:0]  na_st_even;
    logic [3:0]  na_st_fib;
    logic [3:0]  na_st_pal;
    logic        na_is_even;
    logic        na_is_fib;
    logic        na_is_pal;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_number;
    logic [2:0]  res_flags;
    logic        res_timeout;

    int checks = 0;
    int errors = 0;
    int cyc_cnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    na_job_sequencer #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_number(in_number), .na_number(na_number), .na_go(na_go),
        .na_reset(na_reset), .na_st_even(na_st_even), .na_st_fib(na_st_fib),
        .na_st_pal(na_st_pal), .na_is_even(na_is_even), .na_is_fib(na_is_fib),
        .na_is_pal(na_is_pal), .res_valid(res_valid), .res_ready(res_ready),
        .res_number(res_number), .res_flags(res_flags), .res_timeout(res_timeout)
    );

    // ---------------- reference functions ----------------
    function automatic logic fib_of(input logic [31:0] n);
        longint a = 0, b = 1, t;
        while (a < longint'(n)) begin t = a + b; a = b; b = t; end
        return a == longint'(n);
    endfunction

    function automatic logic pal_of(input logic [31:0] n);
        longint x = longint'(n), r = 0;
        while (x > 0) begin r = r * 10 + x % 10; x = x / 10; end
        return r == longint'(n);
    endfunction

    // ---------------- stub analyzer ----------------
    int         lat [3];
    logic       use_b  = 1'b0;
    logic       tog_en = 1'b0;
    int         scnt;
    logic [2:0] sd;
    logic [2:0] tog;
    logic [2:0] tv;

    always @(posedge clk) begin
        if (reset || na_reset || !na_go) begin
            scnt <= 0; sd <= '0; tog <= '0;
        end else begin
            scnt <= scnt + 1;
            for (int u = 0; u < 3; u++) if (scnt + 1 >= lat[u]) sd[u] <= 1'b1;
            if (tog_en) tog <= sd;
        end
    end

    always_comb begin
        tv         = {pal_of(na_number), fib_of(na_number), ~na_number[0]};
        na_st_even = sd[0] ? (use_b ? 2'd3 : 2'd2) : 2'd1;
        na_st_fib  = sd[1] ? (use_b ? 4'd8 : 4'd7) : 4'd3;
        na_st_pal  = sd[2] ? (use_b ? 4'd9 : 4'd6) : 4'd4;
        na_is_even = sd[0] ? (tv[0] ^ tog[0]) : ~tv[0];
        na_is_fib  = sd[1] ? (tv[1] ^ tog[1]) : ~tv[1];
        na_is_pal  = sd[2] ? (tv[2] ^ tog[2]) : ~tv[2];
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc_cnt);
        end
    endtask

    task automatic wait_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired at cycle %0d", name, cyc_cnt);
    endtask

    // ---------------- scoreboard model ----------------
    typedef struct {
        logic [31:0] n;
        logic [2:0]  f;
        logic        t;
    } exp_t;

    exp_t       sb[$];
    logic       tmo_mode = 1'b0;
    logic [2:0] tmo_mask = 3'b111;

    logic        p_hold = 1'b0;
    logic [31:0] p_num;
    logic [2:0]  p_flags;
    logic        p_go = 1'b0;
    logic [31:0] p_na;

    // Per-cycle compare against the job-level model
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                sb.delete();
                p_hold = 1'b0;
                p_go   = 1'b0;
            end else begin
                if (p_hold) begin
                    chk("hold_valid", res_valid, 1);
                    chk("hold_number", res_number, p_num);
                    chk("hold_flags", res_flags, p_flags);
                end
                if (p_go && na_go) chk("na_number_stable", na_number, p_na);
                if (res_valid) chk("go_low_in_report", na_go, 0);
                if (res_valid && res_ready) begin
                    if (sb.size() == 0) begin
                        wait_fail("unexpected_result");
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        chk("res_number", res_number, e.n);
                        chk("res_flags", res_flags, e.f);
                        chk("res_timeout", res_timeout, e.t);
                    end
                end
                if (in_valid && in_ready) begin
                    exp_t e;
                    e.n = in_number;
                    e.f = {pal_of(in_number), fib_of(in_number), ~in_number[0]};
                    if (tmo_mode) e.f = e.f & tmo_mask;
                    e.t = tmo_mode;
                    sb.push_back(e);
                end
                p_hold  = res_valid && !res_ready;
                p_num   = res_number;
                p_flags = res_flags;
                p_go    = na_go;
                p_na    = na_number;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] n);
        int   w;
        logic ok;
        w = 0;
        in_valid  = 1'b1;
        in_number = n;
        do begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            w++;
        end while (!ok && w < 300);
        if (!ok) wait_fail("push");
        in_valid = 1'b0;
    endtask

    task automatic check_reset_vals();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_na_go", na_go, 0);
        chk("rst_na_reset", na_reset, 1);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_number", res_number, 0);
        chk("rst_res_flags", res_flags, 0);
        chk("rst_res_timeout", res_timeout, 0);
        chk("rst_na_number", na_number, 0);
    endtask

    task automatic wait_res_valid(input string name, output int lat_cyc);
        int w, t0;
        w = 0;
        t0 = cyc_cnt;
        do begin @(negedge clk); w++; end while (!res_valid && w < 400);
        if (!res_valid) wait_fail(name);
        lat_cyc = cyc_cnt - t0;
    endtask

    task automatic drain(input string name);
        int w;
        w = 0;
        while ((sb.size() != 0 || res_valid) && w < 600) begin @(negedge clk); w++; end
        if (sb.size() != 0) wait_fail(name);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int lc, w, vcnt, rcnt;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_number = '0;
        res_ready = 1'b0;
        lat[0] = 3; lat[1] = 7; lat[2] = 5;
        cyc(3);
        @(negedge clk);
        check_reset_vals();
        @(posedge clk); #1;
        reset = 1'b0;

        // T1: single job, 55 -> flags {pal,fib,even} = 110
        res_ready = 1'b1;
        push(32'd55);
        wait_res_valid("t1_result", lc);
        chk("t1_number", res_number, 32'd55);
        chk("t1_flags", res_flags, 3'b110);
        chk("t1_timeout", res_timeout, 0);
        chk("t1_latency_min", (lc >= 11) ? 1 : 0, 1);
        drain("t1_drain");

        // T2: backpressure; one job in service plus four buffered fills the FIFO
        lat[0] = 3; lat[1] = 3; lat[2] = 3;
        res_ready = 1'b0;
        push(32'd121); push(32'd8); push(32'd13); push(32'd7); push(32'd1001);
        @(negedge clk);
        chk("t2_in_ready_full", in_ready, 0);
        wait_res_valid("t2_first", lc);
        repeat (10) @(negedge clk);
        chk("t2_still_full", in_ready, 0);
        @(posedge clk); #1;
        res_ready = 1'b1;
        push(32'd34);
        drain("t2_drain");

        // T3: all units finish together, B-variant done states
        lat[0] = 4; lat[1] = 4; lat[2] = 4;
        use_b = 1'b1;
        push(32'd22);
        w = 0;
        do begin @(negedge clk); w++; end while (sd != 3'b111 && w < 100);
        if (sd != 3'b111) wait_fail("t3_all_done");
        chk("t3_go_in_run", na_go, 1);
        @(negedge clk);
        chk("t3_go_release", na_go, 0);
        chk("t3_no_valid_release", res_valid, 0);
        @(negedge clk);
        chk("t3_no_valid_release2", res_valid, 0);
        @(negedge clk);
        chk("t3_valid_report", res_valid, 1);
        chk("t3_flags", res_flags, 3'b101);
        drain("t3_drain");
        use_b = 1'b0;

        // T4: verdicts flip after first done cycle; latch must ignore it
        lat[0] = 2; lat[1] = 5; lat[2] = 8;
        tog_en = 1'b1;
        push(32'd89);
        wait_res_valid("t4_result", lc);
        chk("t4_flags", res_flags, 3'b010);
        drain("t4_drain");
        tog_en = 1'b0;

        // T5: reset during RUN with two numbers queued
        lat[0] = 20; lat[1] = 20; lat[2] = 20;
        push(32'd5); push(32'd6); push(32'd9);
        w = 0;
        do begin @(negedge clk); w++; end while (!na_go && w < 50);
        if (!na_go) wait_fail("t5_go");
        @(posedge clk); #1;
        reset = 1'b1;
        cyc(2);
        @(negedge clk);
        check_reset_vals();
        @(posedge clk); #1;
        reset = 1'b0;
        vcnt = 0;
        repeat (60) begin @(negedge clk); if (res_valid) vcnt++; end
        chk("t5_no_result", vcnt, 0);
        @(posedge clk); #1;
        lat[0] = 2; lat[1] = 2; lat[2] = 2;
        push(32'd8);
        drain("t5_recover");

`ifdef NA_SEQ_TIMEOUT_EN
        // T6: fib never finishes -> watchdog abort
        lat[0] = 2; lat[1] = 1000000; lat[2] = 4;
        tmo_mode = 1'b1;
        tmo_mask = 3'b101;
        res_ready = 1'b0;
        push(32'd55);
        rcnt = 0;
        w = 0;
        do begin
            @(negedge clk);
            w++;
            if (na_reset) rcnt++;
        end while (!res_valid && w < 200);
        if (!res_valid) wait_fail("t6_result");
        chk("t6_timeout", res_timeout, 1);
        chk("t6_flags", res_flags, 3'b100);
        repeat (4) begin @(negedge clk); if (na_reset) rcnt++; end
        chk("t6_reset_pulse", rcnt, 1);
        @(posedge clk); #1;
        res_ready = 1'b1;
        drain("t6_drain");
        tmo_mode = 1'b0;
        tmo_mask = 3'b111;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

endmodule
